// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared FP constants, rounding codes, flag indices, scheduler state.
// Revision: 1.0
// ============================================================================
package fp_pkg;

    localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF  = 32'hFF80_0000;
    localparam logic [31:0] FP_PZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NZERO = 32'h8000_0000;

    localparam logic [2:0] RNe = 3'b000;
    localparam logic [2:0] RZ  = 3'b001;
    localparam logic [2:0] RD  = 3'b010;
    localparam logic [2:0] RU  = 3'b011;
    localparam logic [2:0] RNa = 3'b100;

    // Bit positions inside the 5-bit {ov, un, inv, div_zero, inexact} vector
    localparam int FLG_OV  = 4;
    localparam int FLG_UN  = 3;
    localparam int FLG_INV = 2;
    localparam int FLG_DZ  = 1;
    localparam int FLG_NX  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } div_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first set request at/after ptr.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_pos;
    logic [IW:0]     w_sum;

    // Rotate so that slot ptr lands at bit 0, then lowest set bit wins
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_pos};
    assign o_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ))
                                            : w_sum[IW-1:0];
    assign o_any = |i_req;
    assign o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/fp_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : fp_div_sched
// Brief   : Round-robin scheduler sharing one fp_div among NREQ requesters.
// Revision: 1.0
// ============================================================================
module fp_div_sched
    import fp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int MIN_LAT = 3,
    parameter int TMO     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_in1,
    input  logic [NREQ*W-1:0]       req_in2,
    input  logic [NREQ*3-1:0]       req_rm,
    output logic [W-1:0]            div_in1,
    output logic [W-1:0]            div_in2,
    output logic [2:0]              div_round_m,
    output logic                    div_act,
    input  logic [W-1:0]            div_out,
    input  logic                    div_ov,
    input  logic                    div_un,
    input  logic                    div_inv,
    input  logic                    div_div_zero,
    input  logic                    div_inexact,
    input  logic                    div_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_out,
    output logic [4:0]              rsp_flags,
    output logic                    rsp_tmo,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO + 1);

    div_sched_state_t r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gid;
    logic [CW-1:0]    r_wcnt;
    logic [W-1:0]     r_div_in1;
    logic [W-1:0]     r_div_in2;
    logic [2:0]       r_div_rm;
    logic             r_div_act;
    logic             r_rsp_valid;
    logic [W-1:0]     r_rsp_out;
    logic [4:0]       r_rsp_flags;
    logic             r_rsp_tmo;
    logic             r_busy;

    logic [NREQ-1:0]  w_gnt;
    logic [IW-1:0]    w_gidx;
    logic             w_any;
    logic [IW-1:0]    w_ptr_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    assign req_ready = (r_state == S_IDLE) ? w_gnt : '0;
    assign w_ptr_nxt = (r_gid == IW'(NREQ - 1)) ? '0 : r_gid + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_wcnt      <= '0;
            r_div_in1   <= '0;
            r_div_in2   <= '0;
            r_div_rm    <= '0;
            r_div_act   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
            r_rsp_tmo   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_div_act <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_div_in1 <= req_in1[w_gidx*W +: W];
                        r_div_in2 <= req_in2[w_gidx*W +: W];
                        r_div_rm  <= req_rm[w_gidx*3 +: 3];
                        r_gid     <= w_gidx;
                        r_div_act <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wcnt < CW'(TMO)) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    // A done seen before MIN_LAT belongs to an earlier operation
                    if ((r_wcnt >= CW'(MIN_LAT)) && div_done) begin
                        r_rsp_out   <= div_out;
                        r_rsp_flags <= {div_ov, div_un, div_inv, div_div_zero, div_inexact};
                        r_rsp_tmo   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wcnt == CW'(TMO - 1)) begin
                        r_rsp_out   <= W'(FP_NANQ);
                        r_rsp_flags <= 5'(1 << FLG_INV);
                        r_rsp_tmo   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_nxt;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_in1     = r_div_in1;
    assign div_in2     = r_div_in2;
    assign div_round_m = r_div_rm;
    assign div_act     = r_div_act;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_gid & {IW{r_busy | r_rsp_valid}};
    assign rsp_out     = r_rsp_out;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_tmo     = r_rsp_tmo;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_div_sched
// Brief   : Directed self-checking bench for fp_div_sched with a divider model.
// Revision: 1.0
// ============================================================================
module tb_fp_div_sched;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int MIN_LAT = 3;
    localparam int TMO     = 64;
    localparam int IW      = $clog2(NREQ);

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_in1;
    logic [NREQ*W-1:0] req_in2;
    logic [NREQ*3-1:0] req_rm;
    logic [W-1:0]      div_in1;
    logic [W-1:0]      div_in2;
    logic [2:0]        div_round_m;
    logic              div_act;
    logic [W-1:0]      div_out;
    logic              div_ov, div_un, div_inv, div_div_zero, div_inexact, div_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_out;
    logic [4:0]        rsp_flags;
    logic              rsp_tmo;
    logic              busy;

    fp_div_sched #(
        .NREQ    (NREQ),
        .W       (W),
        .MIN_LAT (MIN_LAT),
        .TMO     (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in1      (req_in1),
        .req_in2      (req_in2),
        .req_rm       (req_rm),
        .div_in1      (div_in1),
        .div_in2      (div_in2),
        .div_round_m  (div_round_m),
        .div_act      (div_act),
        .div_out      (div_out),
        .div_ov       (div_ov),
        .div_un       (div_un),
        .div_inv      (div_inv),
        .div_div_zero (div_div_zero),
        .div_inexact  (div_inexact),
        .div_done     (div_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_out      (rsp_out),
        .rsp_flags    (rsp_flags),
        .rsp_tmo      (rsp_tmo),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Divider model: done pulses m_lat negedges after the act cycle (-1 = never)
    int         m_lat    = -1;
    bit         m_always = 1'b0;
    int         m_cnt    = -1;
    logic [W-1:0] m_out  = '0;
    logic [4:0] m_flags  = '0;

    always @(negedge clk) begin
        if (div_act) m_cnt = 0;
        else if (m_cnt >= 0) m_cnt = m_cnt + 1;
        div_done     = m_always || ((m_lat >= 0) && (m_cnt == m_lat));
        div_out      = m_out;
        div_ov       = m_flags[4];
        div_un       = m_flags[3];
        div_inv      = m_flags[2];
        div_div_zero = m_flags[1];
        div_inexact  = m_flags[0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] slot_in1(input int g);
        return 32'h40C0_0000 | W'(g);
    endfunction

    function automatic logic [W-1:0] slot_in2(input int g);
        return 32'h4000_0000 | W'(g);
    endfunction

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_rsp_valid", rsp_valid, 0);
        check("ack_busy", busy, 0);
    endtask

    // Starts at an IDLE negedge, returns at the first RESP negedge
    task automatic run_op(input logic [NREQ-1:0] vld, input int g, input int exp_lat);
        int lat;
        req_valid = vld;
        #1;
        check("grant_onehot", req_ready, 64'(1) << g);
        @(negedge clk);
        check("issue_act", div_act, 1);
        check("issue_busy", busy, 1);
        check("issue_no_ready", req_ready, 0);
        check("issue_in1", div_in1, slot_in1(g));
        check("issue_in2", div_in2, slot_in2(g));
        check("issue_rm", div_round_m, 3'(g));
        req_valid = '0;
        wait_rsp(lat);
        check("latency", lat + 1, exp_lat);
        check("rsp_id", rsp_id, g);
    endtask

    logic [W-1:0] hold_out;
    logic [4:0]   hold_flags;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_in1[i*W +: W] = slot_in1(i);
            req_in2[i*W +: W] = slot_in2(i);
            req_rm[i*3 +: 3]  = 3'(i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_div_act", div_act, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_in1", div_in1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_grant", busy, 0);

        // Single op: 6.0 / 2.0 = 3.0, done at MIN_LAT+2 after act
        m_lat = MIN_LAT + 2; m_out = 32'h4040_0000; m_flags = 5'b00000;
        run_op(4'b0001, 0, MIN_LAT + 4);
        check("single_out", rsp_out, 32'h4040_0000);
        check("single_flags", rsp_flags, 5'b00000);
        check("single_tmo", rsp_tmo, 0);
        ack();

        // Stale done held high: capture exactly when wcnt reaches MIN_LAT
        m_lat = -1; m_always = 1'b1; m_out = 32'h3F80_0000; m_flags = 5'b00011;
        run_op(4'b0010, 1, MIN_LAT + 3);
        check("stale_out", rsp_out, 32'h3F80_0000);
        check("stale_flags", rsp_flags, 5'b00011);
        ack();
        m_always = 1'b0;

        // Backpressure: 10 cycles of rsp_ready=0 with other requests pending
        m_lat = 4; m_out = 32'h4120_0000; m_flags = 5'b10001;
        run_op(4'b0100, 2, 6);
        hold_out   = rsp_out;
        hold_flags = rsp_flags;
        check("bp_out", hold_out, 32'h4120_0000);
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_out_stable", rsp_out, hold_out);
            check("bp_flags_stable", rsp_flags, hold_flags);
            check("bp_id_stable", rsp_id, 2);
            check("bp_no_ready", req_ready, 0);
            check("bp_no_act", div_act, 0);
            check("bp_div_in1_hold", div_in1, slot_in1(2));
        end
        req_valid = '0;
        ack();

        // Timeout: divider never answers
        m_lat = -1; m_out = 32'h1234_5678; m_flags = 5'b11111;
        run_op(4'b1000, 3, TMO + 2);
        check("tmo_out", rsp_out, 32'h7FC0_0000);
        check("tmo_flags", rsp_flags, 5'b00100);
        check("tmo_flag", rsp_tmo, 1);
        ack();

        // Fairness: everyone valid; ptr wrapped to 0 after the timed-out slot 3
        m_lat = 4; m_out = 32'h3F00_0000; m_flags = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            run_op(4'b1111, k % NREQ, 6);
            check("fair_tmo", rsp_tmo, 0);
            ack();
        end

        // Reset mid-WAIT (ptr is 1 here, so slot 1 is granted)
        m_lat = -1;
        run_op_partial: begin
            req_valid = 4'b1111;
            #1;
            check("rstw_grant", req_ready, 4'b0010);
            repeat (4) @(negedge clk);
            check("rstw_in_wait", busy, 1);
            req_valid = '0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rstw_req_ready", req_ready, 0);
            check("rstw_div_in1", div_in1, 0);
            check("rstw_div_in2", div_in2, 0);
            check("rstw_rm", div_round_m, 0);
            check("rstw_act", div_act, 0);
            check("rstw_rsp_valid", rsp_valid, 0);
            check("rstw_rsp_id", rsp_id, 0);
            check("rstw_rsp_out", rsp_out, 0);
            check("rstw_rsp_flags", rsp_flags, 0);
            check("rstw_rsp_tmo", rsp_tmo, 0);
            check("rstw_busy", busy, 0);
        end
        m_lat = 4; m_out = 32'h4000_0000;
        run_op(4'b1111, 0, 6);
        check("post_rst_out", rsp_out, 32'h4000_0000);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
